uart_receiver: RTL and testbench

- Serial-to-parallel UART receiver; the receive-side counterpart of the team's UART transmitter.
- Oversamples the asynchronous rx line using the shared 16x baud tick (s_tick) and reassembles LSB-first frames: 1 start bit, DBIT data bits, stop period of SB_TICK ticks.
- Delivers each byte on dout with a one-cycle rx_done_tick strobe to the PicoBlaze input-port/FIFO logic.
- Adds start-bit glitch rejection and stop-bit framing-error detection.

---
 rtl/uart_receiver.sv | 137 +++++++++++++
 tb/tb_uart_receiver.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_receiver.sv
// UART receiver: 16x oversampled, LSB-first frames with start-glitch rejection
// and stop-bit framing-error flag. Pairs with the team's UART transmitter.
module uart_receiver #(
  parameter int DBIT    = 8,   // data bits per frame, 6..8
  parameter int SB_TICK = 16   // stop period in s_ticks: 16/24/32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  input  logic       s_tick,
  output logic [7:0] dout,
  output logic       rx_done_tick,
  output logic       frame_err
);

  // The tick counter must hold SB_TICK-1 for long stop periods.
  localparam int S_MAX = (SB_TICK > 16) ? SB_TICK : 16;
  localparam int S_W   = $clog2(S_MAX);

  localparam logic [S_W-1:0] S_MID  = S_W'(7);
  localparam logic [S_W-1:0] S_BIT  = S_W'(15);
  localparam logic [S_W-1:0] S_STOP = S_W'(SB_TICK - 1);
  localparam logic [2:0]     N_LAST = 3'(DBIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t         state_reg, state_next;
  logic [S_W-1:0] s_reg, s_next;
  logic [2:0]     n_reg, n_next;
  logic [7:0]     b_reg, b_next;
  logic           ferr_reg, ferr_next;
  logic           done_reg, done_next;
  logic           rx_meta, rx_s;

  // Two-flop synchronizer; resets to the idle line level so reset never
  // looks like a start edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments keep rx_s one stage behind rx_meta;
      // blocking here would collapse the two flops into one.
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // NOTE: the shift register is a handful of flops, not a memory, so it is
  // reset like every other register here.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      s_reg     <= '0;
      n_reg     <= '0;
      b_reg     <= '0;
      ferr_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      s_reg     <= s_next;
      n_reg     <= n_next;
      b_reg     <= b_next;
      ferr_reg  <= ferr_next;
      done_reg  <= done_next;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case can infer a latch.
    state_next = state_reg;
    s_next     = s_reg;
    n_next     = n_reg;
    b_next     = b_reg;
    ferr_next  = ferr_reg;
    done_next  = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (!rx_s) begin
          state_next = START;
          s_next     = '0;
        end
      end
      START: begin
        if (s_tick) begin
          if (s_reg == S_MID) begin
            if (!rx_s) begin
              state_next = DATA;
              s_next     = '0;
              n_next     = '0;
            end else begin
              state_next = IDLE;  // line back high mid start bit: glitch
            end
          end else begin
            s_next = s_reg + S_W'(1);
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s_reg == S_BIT) begin
            b_next = {rx_s, b_reg[7:1]};
            s_next = '0;
            if (n_reg == N_LAST) state_next = STOP;
            else                 n_next     = n_reg + 3'd1;
          end else begin
            s_next = s_reg + S_W'(1);
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if (s_reg == S_STOP) begin
            state_next = IDLE;
            done_next  = 1'b1;
            ferr_next  = ~rx_s;
          end else begin
            s_next = s_reg + S_W'(1);
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Strobe is registered so it lands in the same cycle frame_err updates.
  assign dout         = b_reg;
  assign rx_done_tick = done_reg;
  assign frame_err    = ferr_reg;

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver (DBIT=8, SB_TICK=16, s_tick every 4 clk):
// directed table, multi-cycle corner sequences, and random frames vs a frame model.
`timescale 1ns/1ps
module tb_uart_receiver;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx;
  logic       s_tick = 1'b0;
  logic [7:0] dout;
  logic       rx_done_tick;
  logic       frame_err;

  uart_receiver #(.DBIT(8), .SB_TICK(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .rx           (rx),
    .s_tick       (s_tick),
    .dout         (dout),
    .rx_done_tick (rx_done_tick),
    .frame_err    (frame_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int total_ticks = 0;
  int start_tick = 0;
  bit tick_en = 1'b1;

  typedef struct {
    logic [7:0] data;
    logic       ferr;
    int         tick;
  } obs_t;

  typedef struct {
    logic [7:0] data;
    bit         stop_ok;
    int         gap;
    logic [7:0] exp_dout;
    logic       exp_ferr;
  } vec_t;

  typedef struct {
    logic [7:0] data;
    logic       ferr;
  } exp_t;

  obs_t obs_q[$];
  exp_t exp_q[$];

  // s_tick: one clk high every 4 clk, changed 2 ns after the rising edge.
  initial begin
    int cyc = 0;
    forever begin
      @(posedge clk);
      #2;
      cyc++;
      s_tick = tick_en && (cyc % 4 == 0);
      if (s_tick) total_ticks++;
    end
  end

  // Strobe monitor, sampled on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rx_done_tick) obs_q.push_back('{dout, frame_err, total_ticks});
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Returns at +3 ns after the edge on which the n-th further tick acts.
  task automatic tick_wait(input int n);
    int k = 0;
    while (k < n) begin
      @(posedge clk);
      #3;
      if (s_tick) k++;
    end
  endtask

  // A bad stop bit is low for 12 ticks (covering the DUT's sample point),
  // then high long enough for the receiver to settle back to idle.
  task automatic send_frame(input logic [7:0] data, input bit stop_ok, input int gap);
    rx = 1'b0;
    start_tick = total_ticks;
    tick_wait(16);
    for (int i = 0; i < 8; i++) begin
      rx = data[i];
      tick_wait(16);
    end
    if (stop_ok) begin
      rx = 1'b1;
      tick_wait(16);
    end else begin
      rx = 1'b0;
      tick_wait(12);
      rx = 1'b1;
      tick_wait(12);
    end
    rx = 1'b1;
    if (gap > 0) tick_wait(gap);
  endtask

  task automatic expect_frame(input string name, input logic [7:0] d, input logic fe,
                              output int tick);
    obs_t o;
    tick = -1;
    if (obs_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s strobe: got none, expected one", name);
    end else begin
      o = obs_q.pop_front();
      tick = o.tick;
      check({name, " dout"}, {24'd0, o.data}, {24'd0, d});
      check({name, " frame_err"}, {31'd0, o.ferr}, {31'd0, fe});
    end
  endtask

  vec_t vecs[6];

  initial begin
    int t;
    logic [7:0] held;
    reset = 1'b1;
    rx    = 1'b1;

    vecs[0] = '{8'hA5, 1'b1, 4, 8'hA5, 1'b0};
    vecs[1] = '{8'h3C, 1'b0, 4, 8'h3C, 1'b1};
    vecs[2] = '{8'h5A, 1'b1, 4, 8'h5A, 1'b0};
    vecs[3] = '{8'h00, 1'b1, 0, 8'h00, 1'b0};
    vecs[4] = '{8'hFF, 1'b1, 0, 8'hFF, 1'b0};
    vecs[5] = '{8'h81, 1'b1, 4, 8'h81, 1'b0};

    repeat (3) @(posedge clk);
    #3;
    check("reset dout", {24'd0, dout}, 32'h0);
    check("reset rx_done_tick", {31'd0, rx_done_tick}, 32'h0);
    check("reset frame_err", {31'd0, frame_err}, 32'h0);
    reset = 1'b0;
    tick_wait(8);

    // Directed table: data, framing error, latency and held outputs.
    for (int i = 0; i < 6; i++) begin
      send_frame(vecs[i].data, vecs[i].stop_ok, vecs[i].gap);
      expect_frame($sformatf("vec%0d", i), vecs[i].exp_dout, vecs[i].exp_ferr, t);
      if (t >= 0) check_range($sformatf("vec%0d latency", i), t - start_tick, 151, 153);
      check($sformatf("vec%0d dout held", i), {24'd0, dout}, {24'd0, vecs[i].exp_dout});
      check($sformatf("vec%0d frame_err held", i), {31'd0, frame_err}, {31'd0, vecs[i].exp_ferr});
      check($sformatf("vec%0d single strobe", i), obs_q.size(), 0);
    end

    // Bad stop frame, then a 5-tick start glitch that must be rejected.
    send_frame(8'hE7, 1'b0, 8);
    expect_frame("bad stop E7", 8'hE7, 1'b1, t);
    rx = 1'b0;
    tick_wait(5);
    rx = 1'b1;
    tick_wait(24);
    check("glitch no strobe", obs_q.size(), 0);
    check("glitch dout kept", {24'd0, dout}, 32'hE7);
    check("glitch frame_err kept", {31'd0, frame_err}, 32'h1);

    // Break: line low for 308 ticks gives two all-zero frames with framing error.
    rx = 1'b0;
    start_tick = total_ticks;
    tick_wait(308);
    rx = 1'b1;
    tick_wait(24);
    expect_frame("break 1", 8'h00, 1'b1, t);
    if (t >= 0) check_range("break 1 latency", t - start_tick, 151, 153);
    expect_frame("break 2", 8'h00, 1'b1, t);
    if (t >= 0) check_range("break 2 latency", t - start_tick, 303, 305);
    check("break strobe count", obs_q.size(), 0);

    // Reset pulsed during data bit 4 of 0x96, then a clean 0x69.
    send_frame(8'h5A, 1'b0, 8);
    expect_frame("pre-reset", 8'h5A, 1'b1, t);
    rx = 1'b0;
    tick_wait(16);
    for (int i = 0; i < 4; i++) begin
      rx = 8'h96 >> i;
      tick_wait(16);
    end
    rx = 1'b1;          // bit 4 of 0x96
    tick_wait(8);
    reset = 1'b1;
    #1;
    check("mid reset dout", {24'd0, dout}, 32'h0);
    check("mid reset frame_err", {31'd0, frame_err}, 32'h0);
    check("mid reset rx_done_tick", {31'd0, rx_done_tick}, 32'h0);
    tick_wait(2);
    reset = 1'b0;
    rx    = 1'b1;
    tick_wait(200);
    check("aborted frame no strobe", obs_q.size(), 0);
    send_frame(8'h69, 1'b1, 4);
    expect_frame("post-reset 69", 8'h69, 1'b0, t);
    if (t >= 0) check_range("post-reset latency", t - start_tick, 151, 153);

    // s_tick gated off for 50 clk during data bit 3 of 0xC3.
    fork
      send_frame(8'hC3, 1'b1, 4);
      begin
        tick_wait(70);
        tick_en = 1'b0;
        held = dout;
        repeat (50) @(posedge clk);
        #3;
        check("gated dout frozen", {24'd0, dout}, {24'd0, held});
        check("gated no strobe", obs_q.size(), 0);
        tick_en = 1'b1;
      end
    join
    expect_frame("gated C3", 8'hC3, 1'b0, t);

    // Random frames vs the frame-level model: byte in, byte out, ferr = bad stop.
    for (int i = 0; i < 12; i++) begin
      logic [7:0] d;
      bit         ok;
      exp_t       e;
      d  = 8'($urandom);
      ok = ($urandom_range(0, 3) != 0);
      exp_q.push_back('{d, ~ok});
      send_frame(d, ok, ok ? int'($urandom_range(0, 10)) : 8);
      e = exp_q.pop_front();
      expect_frame($sformatf("rand%0d", i), e.data, e.ferr, t);
    end

    tick_wait(40);
    check("no stray strobes", obs_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
